axi_lite_to_apb: RTL and testbench
==================================

// Module: axi_lite_to_apb
// PURPOSE
// - Bridges one AXI4-Lite slave port to one APB4 master port; sits downstream of the axi_multicut register slices on the peripheral path.
// - Converts each AXI-Lite read or write into exactly one APB SETUP/ACCESS transfer.
// - Returns PREADY/PSLVERR as an R or B response.
// - One transaction in flight; address decode to individual PSELs is done outside this block.
// PARAMETERS
// AddrWidth  32  AXI/APB address width (PADDR = AxADDR[AddrWidth-1:0], unmodified)
// DataWidth  32  data width; only 32 supported, elaboration error otherwise
// PORTS
// clk_i       in   1    single clock, all logic rising-edge
// rst_i       in   1    synchronous reset, active-high
// awaddr_i    in   AW   write address;  awprot_i in 3;  awvalid_i in 1;  awready_o out 1
// wdata_i     in   32   write data;  wstrb_i in 4;  wvalid_i in 1;  wready_o out 1
// bresp_o     out  2    write response;  bvalid_o out 1;  bready_i in 1
// araddr_i    in   AW   read address;  arprot_i in 3;  arvalid_i in 1;  arready_o out 1
// rdata_o     out  32   read data;  rresp_o out 2;  rvalid_o out 1;  rready_i in 1
// paddr_o     out  AW   APB address;  pprot_o out 3;  psel_o out 1;  penable_o out 1
// pwrite_o    out  1    1 = write transfer;  pwdata_o out 32;  pstrb_o out 4
// prdata_i    in   32   APB read data;  pready_i in 1;  pslverr_i in 1
// BEHAVIOUR
// - Reset (rst_i=1 at a clock edge):
//   - state=IDLE; AW/W/AR holding regs emptied; arbitration flag = write-last.
//   - All *valid_o, psel_o, penable_o, pwrite_o = 0.
//   - All *ready_o = 0 while rst_i=1.
//   - Data, address and resp outputs = 0.
// - Input buffering: one-entry holding regs for AW, W and AR.
//   - awready_o = ~aw_full & ~rst_i; wready_o = ~w_full & ~rst_i; arready_o = ~ar_full & ~rst_i.
//   - AW and W are accepted independently, in any order or the same cycle.
//   - A write is eligible only when both aw_full and w_full are set.
// - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
// - IDLE:
//   - If exactly one of (write eligible, ar_full) holds, grant it.
//   - If both hold, grant the type not granted last (round-robin). The first tie after reset goes to read.
//   - On grant: latch PADDR, PPROT, PWRITE, PWDATA and PSTRB (PSTRB=0 on reads); go to SETUP.
// - SETUP: psel_o=1, penable_o=0; exactly one cycle; next state ACCESS.
// - ACCESS:
//   - psel_o=1, penable_o=1; hold every P* output stable until pready_i=1.
//   - On pready_i: capture prdata_i (reads) and pslverr_i; clear the consumed holding regs; go to RESP.
// - RESP:
//   - Assert rvalid_o or bvalid_o with resp = pslverr ? 2'b10 (SLVERR) : 2'b00 (OKAY).
//   - rdata_o holds the captured data; it is 0 on a read with pslverr.
//   - Hold the response until the R or B handshake; then go to IDLE. Next grant is possible in that same IDLE cycle's evaluation.
// - Latency with zero-wait APB and ready master, from the AR/AW+W acceptance edge:
//   - SETUP in cycle +1, ACCESS in cycle +2, R/B valid in cycle +3.
//   - Back-to-back accesses every 4 cycles.
// - Holding regs may refill during SETUP/ACCESS/RESP. A new AR is accepted while a write is on APB, and vice versa; no second APB transfer starts before RESP completes.
// - psel_o/penable_o are never asserted outside SETUP/ACCESS; penable_o never rises without psel_o already high.
// - The AXI ID-free ordering rules are met by construction: single outstanding, R/B strictly in grant order.
// - Reset mid-transfer (any state): abandons the APB access and any pending response.
//   - psel/penable drop at that edge; no R/B is issued for the abandoned transaction.
// STRUCTURE
// - Package axi_apb_pkg: state enum (IDLE, SETUP, ACCESS, RESP), RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 constants, APB strobe width localparam.
// - No sub-module: holding regs, arbiter flag and FSM are kept in one always block plus output assigns.
// TESTING
// - Single read: AR 0x40 with PREADY immediate and PRDATA 0xDEADBEEF.
//   - PSEL at +1, PENABLE at +2; R valid at +3 with RDATA=0xDEADBEEF, RRESP=00.
// - Write with W one cycle before AW: addr 0x10, data 0x12345678, strb 4'b0110.
//   - PWRITE=1 and PSTRB=0110 throughout; B valid with BRESP=00.
// - Wait states: PREADY low for 5 ACCESS cycles.
//   - PADDR/PWDATA/PSEL/PENABLE stable for all 6 ACCESS cycles; response 1 cycle after PREADY.
// - Read and write eligible in the same IDLE cycle.
//   - Read goes first, write second; with repeated ties, grants alternate R,W,R,W.
// - PSLVERR=1 on a read: RRESP=10, RDATA=0. BREADY held low 10 cycles: BVALID held, no new PSEL.
// - rst_i asserted during ACCESS:
//   - next cycle PSEL=0 and all valids 0; no response is issued for the abandoned transaction.
//   - After release, a fresh read completes normally.

Source files
------------

// File: rtl/axi_apb_pkg.sv
// Shared types and constants for the AXI4-Lite to APB4 bridge.
package axi_apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int unsigned APB_STRB_W = 4;

endpackage

// File: rtl/axi_lite_to_apb.sv
// AXI4-Lite slave to APB4 master bridge. Each accepted read, or each
// accepted AW+W pair, becomes one APB SETUP/ACCESS transfer whose
// PREADY/PSLVERR result is returned on R or B. One transaction is in
// flight at a time; reads and writes that are ready together alternate.
module axi_lite_to_apb
   import axi_apb_pkg::*;
#(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,

   input  logic [AddrWidth-1:0]  awaddr_i,
   input  logic [2:0]            awprot_i,
   input  logic                  awvalid_i,
   output logic                  awready_o,

   input  logic [DataWidth-1:0]  wdata_i,
   input  logic [APB_STRB_W-1:0] wstrb_i,
   input  logic                  wvalid_i,
   output logic                  wready_o,

   output logic [1:0]            bresp_o,
   output logic                  bvalid_o,
   input  logic                  bready_i,

   input  logic [AddrWidth-1:0]  araddr_i,
   input  logic [2:0]            arprot_i,
   input  logic                  arvalid_i,
   output logic                  arready_o,

   output logic [DataWidth-1:0]  rdata_o,
   output logic [1:0]            rresp_o,
   output logic                  rvalid_o,
   input  logic                  rready_i,

   output logic [AddrWidth-1:0]  paddr_o,
   output logic [2:0]            pprot_o,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [DataWidth-1:0]  pwdata_o,
   output logic [APB_STRB_W-1:0] pstrb_o,
   input  logic [DataWidth-1:0]  prdata_i,
   input  logic                  pready_i,
   input  logic                  pslverr_i
);

   // The strobe and byte-lane handling only make sense for a 32-bit bus.
   if (DataWidth != 32) begin : g_width_check
      $error("axi_lite_to_apb supports DataWidth = 32 only");
   end

   apb_state_e state;
   apb_state_e state_next;

   logic                  aw_full;
   logic [AddrWidth-1:0]  aw_addr;
   logic [2:0]            aw_prot;
   logic                  w_full;
   logic [DataWidth-1:0]  w_data;
   logic [APB_STRB_W-1:0] w_strb;
   logic                  ar_full;
   logic [AddrWidth-1:0]  ar_addr;
   logic [2:0]            ar_prot;

   logic                  last_write;

   logic [AddrWidth-1:0]  paddr_q;
   logic [2:0]            pprot_q;
   logic                  pwrite_q;
   logic [DataWidth-1:0]  pwdata_q;
   logic [APB_STRB_W-1:0] pstrb_q;
   logic [1:0]            resp_q;
   logic [DataWidth-1:0]  rdata_q;

   logic aw_take;
   logic w_take;
   logic ar_take;
   logic wr_eligible;
   logic grant_write;
   logic grant_read;
   logic apb_done;
   logic resp_done;

   assign awready_o   = ~aw_full & ~rst_i;
   assign wready_o    = ~w_full & ~rst_i;
   assign arready_o   = ~ar_full & ~rst_i;

   assign aw_take     = awvalid_i & awready_o;
   assign w_take      = wvalid_i & wready_o;
   assign ar_take     = arvalid_i & arready_o;

   assign wr_eligible = aw_full & w_full;
   assign apb_done    = (state == ACCESS) & pready_i;
   assign resp_done   = pwrite_q ? bready_i : rready_i;

   // Next state and grant decision; the tie goes to whichever type did not win last.
   always_comb begin
      state_next  = state;
      grant_write = 1'b0;
      grant_read  = 1'b0;
      case (state)
         IDLE: begin
            if (wr_eligible && (!ar_full || !last_write)) begin
               grant_write = 1'b1;
               state_next  = SETUP;
            end else if (ar_full) begin
               grant_read = 1'b1;
               state_next = SETUP;
            end
         end
         SETUP:   state_next = ACCESS;
         ACCESS:  if (pready_i) state_next = RESP;
         RESP:    if (resp_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register; reset abandons any transfer or pending response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Holding registers, APB transfer latches and captured response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         aw_full    <= 1'b0;
         aw_addr    <= '0;
         aw_prot    <= '0;
         w_full     <= 1'b0;
         w_data     <= '0;
         w_strb     <= '0;
         ar_full    <= 1'b0;
         ar_addr    <= '0;
         ar_prot    <= '0;
         last_write <= 1'b1;
         paddr_q    <= '0;
         pprot_q    <= '0;
         pwrite_q   <= 1'b0;
         pwdata_q   <= '0;
         pstrb_q    <= '0;
         resp_q     <= RESP_OKAY;
         rdata_q    <= '0;
      end else begin
         if (aw_take) begin
            aw_full <= 1'b1;
            aw_addr <= awaddr_i;
            aw_prot <= awprot_i;
         end
         if (w_take) begin
            w_full <= 1'b1;
            w_data <= wdata_i;
            w_strb <= wstrb_i;
         end
         if (ar_take) begin
            ar_full <= 1'b1;
            ar_addr <= araddr_i;
            ar_prot <= arprot_i;
         end

         if (grant_write) begin
            paddr_q    <= aw_addr;
            pprot_q    <= aw_prot;
            pwrite_q   <= 1'b1;
            pwdata_q   <= w_data;
            pstrb_q    <= w_strb;
            last_write <= 1'b1;
         end else if (grant_read) begin
            paddr_q    <= ar_addr;
            pprot_q    <= ar_prot;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            last_write <= 1'b0;
         end

         if (apb_done) begin
            resp_q <= pslverr_i ? RESP_SLVERR : RESP_OKAY;
            if (pwrite_q) begin
               aw_full <= 1'b0;
               w_full  <= 1'b0;
            end else begin
               ar_full <= 1'b0;
               rdata_q <= pslverr_i ? '0 : prdata_i;
            end
         end
      end
   end

   assign psel_o    = (state == SETUP) || (state == ACCESS);
   assign penable_o = (state == ACCESS);
   assign paddr_o   = paddr_q;
   assign pprot_o   = pprot_q;
   assign pwrite_o  = pwrite_q;
   assign pwdata_o  = pwdata_q;
   assign pstrb_o   = pstrb_q;

   assign bvalid_o  = (state == RESP) & pwrite_q;
   assign rvalid_o  = (state == RESP) & ~pwrite_q;
   assign bresp_o   = resp_q;
   assign rresp_o   = resp_q;
   assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_axi_lite_to_apb.sv
// Self-checking bench for axi_lite_to_apb: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// transaction-level model of the bridge kept in this file.
module tb_axi_lite_to_apb;

   logic        clk_i;
   logic        rst_i;
   logic [31:0] awaddr_i;
   logic [2:0]  awprot_i;
   logic        awvalid_i;
   logic        awready_o;
   logic [31:0] wdata_i;
   logic [3:0]  wstrb_i;
   logic        wvalid_i;
   logic        wready_o;
   logic [1:0]  bresp_o;
   logic        bvalid_o;
   logic        bready_i;
   logic [31:0] araddr_i;
   logic [2:0]  arprot_i;
   logic        arvalid_i;
   logic        arready_o;
   logic [31:0] rdata_o;
   logic [1:0]  rresp_o;
   logic        rvalid_o;
   logic        rready_i;
   logic [31:0] paddr_o;
   logic [2:0]  pprot_o;
   logic        psel_o;
   logic        penable_o;
   logic        pwrite_o;
   logic [31:0] pwdata_o;
   logic [3:0]  pstrb_o;
   logic [31:0] prdata_i;
   logic        pready_i;
   logic        pslverr_i;

   axi_lite_to_apb #(
      .AddrWidth(32),
      .DataWidth(32)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .awaddr_i(awaddr_i), .awprot_i(awprot_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
      .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
      .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
      .araddr_i(araddr_i), .arprot_i(arprot_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
      .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
      .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
      .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
      .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;
   bit compare_en = 1'b0;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  prot;
   } addr_beat_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
   } data_beat_t;

   // Transaction-level model: pending requests, the one transfer in flight,
   // how many cycles it has been on APB, and the result it will return.
   addr_beat_t aw_q[$];
   addr_beat_t ar_q[$];
   data_beat_t w_q[$];
   bit          m_active;
   bit          m_apb_done;
   bit          m_cur_write;
   bit          m_last_write;
   int          m_age;
   logic [31:0] m_paddr;
   logic [2:0]  m_pprot;
   logic [31:0] m_pwdata;
   logic [3:0]  m_pstrb;
   logic [1:0]  m_resp;
   logic [31:0] m_rdata;
   bit          aw_hs;
   bit          w_hs;
   bit          ar_hs;
   bit          aw_acc;
   bit          w_acc;
   bit          ar_acc;
   bit          wr_ok;
   bit          rd_ok;
   addr_beat_t  a_tmp;
   data_beat_t  d_tmp;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using only bench-driven inputs.
   always @(posedge clk_i) begin
      if (rst_i) begin
         aw_q.delete();
         w_q.delete();
         ar_q.delete();
         m_active     = 1'b0;
         m_apb_done   = 1'b0;
         m_cur_write  = 1'b0;
         m_last_write = 1'b1;
         m_age        = 0;
         m_resp       = 2'b00;
         m_rdata      = 32'h0;
         aw_hs        = 1'b0;
         w_hs         = 1'b0;
         ar_hs        = 1'b0;
      end else begin
         aw_acc = awvalid_i && (aw_q.size() == 0);
         w_acc  = wvalid_i && (w_q.size() == 0);
         ar_acc = arvalid_i && (ar_q.size() == 0);
         if (m_active) begin
            if (!m_apb_done) begin
               if (m_age >= 2 && pready_i) begin
                  m_apb_done = 1'b1;
                  m_resp     = pslverr_i ? 2'b10 : 2'b00;
                  if (m_cur_write) begin
                     void'(aw_q.pop_front());
                     void'(w_q.pop_front());
                  end else begin
                     m_rdata = pslverr_i ? 32'h0 : prdata_i;
                     void'(ar_q.pop_front());
                  end
               end
            end else if (m_cur_write ? bready_i : rready_i) begin
               m_active = 1'b0;
            end
            m_age++;
         end else begin
            wr_ok = (aw_q.size() > 0) && (w_q.size() > 0);
            rd_ok = (ar_q.size() > 0);
            if (wr_ok && (!rd_ok || !m_last_write)) begin
               m_cur_write  = 1'b1;
               m_paddr      = aw_q[0].addr;
               m_pprot      = aw_q[0].prot;
               m_pwdata     = w_q[0].data;
               m_pstrb      = w_q[0].strb;
               m_last_write = 1'b1;
               m_active     = 1'b1;
               m_apb_done   = 1'b0;
               m_age        = 1;
            end else if (rd_ok) begin
               m_cur_write  = 1'b0;
               m_paddr      = ar_q[0].addr;
               m_pprot      = ar_q[0].prot;
               m_pwdata     = 32'h0;
               m_pstrb      = 4'h0;
               m_last_write = 1'b0;
               m_active     = 1'b1;
               m_apb_done   = 1'b0;
               m_age        = 1;
            end
         end
         if (aw_acc) begin
            a_tmp.addr = awaddr_i;
            a_tmp.prot = awprot_i;
            aw_q.push_back(a_tmp);
         end
         if (w_acc) begin
            d_tmp.data = wdata_i;
            d_tmp.strb = wstrb_i;
            w_q.push_back(d_tmp);
         end
         if (ar_acc) begin
            a_tmp.addr = araddr_i;
            a_tmp.prot = arprot_i;
            ar_q.push_back(a_tmp);
         end
         aw_hs = aw_acc;
         w_hs  = w_acc;
         ar_hs = ar_acc;
      end
   end

   logic exp_psel;
   logic exp_pen;
   logic exp_bv;
   logic exp_rv;

   // Compare every DUT output against the model once per cycle, mid-cycle.
   always @(negedge clk_i) begin
      if (compare_en) begin
         #2;
         exp_psel = m_active && !m_apb_done;
         exp_pen  = exp_psel && (m_age >= 2);
         exp_bv   = m_active && m_apb_done && m_cur_write;
         exp_rv   = m_active && m_apb_done && !m_cur_write;
         check_bit("awready", awready_o, !rst_i && (aw_q.size() == 0));
         check_bit("wready", wready_o, !rst_i && (w_q.size() == 0));
         check_bit("arready", arready_o, !rst_i && (ar_q.size() == 0));
         check_bit("psel", psel_o, exp_psel);
         check_bit("penable", penable_o, exp_pen);
         check_bit("bvalid", bvalid_o, exp_bv);
         check_bit("rvalid", rvalid_o, exp_rv);
         if (exp_psel) begin
            check_output("paddr", paddr_o, m_paddr);
            check_output("pprot", 32'(pprot_o), 32'(m_pprot));
            check_bit("pwrite", pwrite_o, m_cur_write);
            check_output("pstrb", 32'(pstrb_o), 32'(m_pstrb));
            if (m_cur_write) check_output("pwdata", pwdata_o, m_pwdata);
         end
         if (exp_rv) begin
            check_output("rdata", rdata_o, m_rdata);
            check_output("rresp", 32'(rresp_o), 32'(m_resp));
         end
         if (exp_bv) check_output("bresp", 32'(bresp_o), 32'(m_resp));
      end
   end

   // Move to the next falling edge and drop any valid that was just accepted.
   task automatic tick();
      @(negedge clk_i);
      if (awvalid_i && aw_hs) awvalid_i = 1'b0;
      if (wvalid_i && w_hs) wvalid_i = 1'b0;
      if (arvalid_i && ar_hs) arvalid_i = 1'b0;
   endtask

   task automatic apply_reset();
      tick();
      rst_i     = 1'b1;
      awvalid_i = 1'b0;
      wvalid_i  = 1'b0;
      arvalid_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   // One cycle of random master, slave and reset activity; valids hold until accepted.
   task automatic apply_stimulus();
      rst_i = ($urandom_range(0, 299) == 0);
      if (!awvalid_i && $urandom_range(0, 3) == 0) begin
         awvalid_i = 1'b1;
         awaddr_i  = $urandom;
         awprot_i  = 3'($urandom);
      end
      if (!wvalid_i && $urandom_range(0, 3) == 0) begin
         wvalid_i = 1'b1;
         wdata_i  = $urandom;
         wstrb_i  = 4'($urandom);
      end
      if (!arvalid_i && $urandom_range(0, 3) == 0) begin
         arvalid_i = 1'b1;
         araddr_i  = $urandom;
         arprot_i  = 3'($urandom);
      end
      bready_i  = ($urandom_range(0, 2) != 0);
      rready_i  = ($urandom_range(0, 2) != 0);
      pready_i  = ($urandom_range(0, 2) != 0);
      pslverr_i = ($urandom_range(0, 4) == 0);
      prdata_i  = $urandom;
   endtask

   task automatic wait_rvalid(input string name, input int limit);
      int k;
      k = 0;
      while (!rvalid_o && k < limit) begin
         tick();
         #2;
         k++;
      end
      check_bit(name, rvalid_o, 1'b1);
   endtask

   logic order [4];
   int   n_grants;

   initial begin
      rst_i = 1'b1;
      awaddr_i = '0; awprot_i = '0; awvalid_i = 1'b0;
      wdata_i = '0; wstrb_i = '0; wvalid_i = 1'b0;
      araddr_i = '0; arprot_i = '0; arvalid_i = 1'b0;
      bready_i = 1'b0; rready_i = 1'b0;
      prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;

      // Reset values
      repeat (2) @(negedge clk_i);
      compare_en = 1'b1;
      #2;
      check_bit("rst_awready", awready_o, 1'b0);
      check_bit("rst_arready", arready_o, 1'b0);
      check_bit("rst_psel", psel_o, 1'b0);
      check_bit("rst_pwrite", pwrite_o, 1'b0);
      check_output("rst_paddr", paddr_o, 32'h0);
      check_output("rst_rdata", rdata_o, 32'h0);
      check_output("rst_pstrb", 32'(pstrb_o), 32'h0);
      tick();
      rst_i = 1'b0;

      // Single read, zero-wait APB
      tick();
      pready_i = 1'b1; prdata_i = 32'hDEADBEEF; rready_i = 1'b1;
      arvalid_i = 1'b1; araddr_i = 32'h40; arprot_i = 3'b000;
      tick(); #2;
      check_bit("rd_c0_psel", psel_o, 1'b0);
      tick(); #2;
      check_bit("rd_c1_psel", psel_o, 1'b1);
      check_bit("rd_c1_penable", penable_o, 1'b0);
      check_output("rd_c1_paddr", paddr_o, 32'h40);
      tick(); #2;
      check_bit("rd_c2_penable", penable_o, 1'b1);
      tick(); #2;
      check_bit("rd_c3_rvalid", rvalid_o, 1'b1);
      check_output("rd_c3_rdata", rdata_o, 32'hDEADBEEF);
      check_output("rd_c3_rresp", 32'(rresp_o), 32'h0);
      tick(); #2;
      check_bit("rd_c4_rvalid", rvalid_o, 1'b0);

      // Write with W one cycle ahead of AW
      tick();
      bready_i = 1'b1;
      wvalid_i = 1'b1; wdata_i = 32'h12345678; wstrb_i = 4'b0110;
      tick();
      awvalid_i = 1'b1; awaddr_i = 32'h10; awprot_i = 3'b010;
      #2;
      check_bit("wr_wonly_psel", psel_o, 1'b0);
      tick(); #2;
      check_bit("wr_c0_psel", psel_o, 1'b0);
      tick(); #2;
      check_bit("wr_c1_psel", psel_o, 1'b1);
      check_bit("wr_c1_pwrite", pwrite_o, 1'b1);
      check_output("wr_c1_pstrb", 32'(pstrb_o), 32'h6);
      check_output("wr_c1_paddr", paddr_o, 32'h10);
      check_output("wr_c1_pwdata", pwdata_o, 32'h12345678);
      tick(); #2;
      check_bit("wr_c2_penable", penable_o, 1'b1);
      check_bit("wr_c2_pwrite", pwrite_o, 1'b1);
      check_output("wr_c2_pstrb", 32'(pstrb_o), 32'h6);
      tick(); #2;
      check_bit("wr_c3_bvalid", bvalid_o, 1'b1);
      check_output("wr_c3_bresp", 32'(bresp_o), 32'h0);

      // Five wait states on a write
      tick();
      pready_i = 1'b0;
      awvalid_i = 1'b1; awaddr_i = 32'h0000_0A00; awprot_i = 3'b001;
      wvalid_i = 1'b1; wdata_i = 32'hA5A5_0F0F; wstrb_i = 4'b1111;
      tick();
      tick();
      for (int k = 0; k < 6; k++) begin
         tick();
         if (k == 5) pready_i = 1'b1;
         #2;
         check_bit($sformatf("ws_acc%0d_psel", k), psel_o, 1'b1);
         check_bit($sformatf("ws_acc%0d_penable", k), penable_o, 1'b1);
         check_output($sformatf("ws_acc%0d_paddr", k), paddr_o, 32'h0000_0A00);
         check_output($sformatf("ws_acc%0d_pwdata", k), pwdata_o, 32'hA5A5_0F0F);
      end
      tick(); #2;
      check_bit("ws_bvalid", bvalid_o, 1'b1);

      // Read and write tied after reset: grants must alternate R,W,R,W
      apply_reset();
      pready_i = 1'b1; pslverr_i = 1'b0; rready_i = 1'b1; bready_i = 1'b1;
      n_grants = 0;
      for (int c = 0; c < 40 && n_grants < 4; c++) begin
         tick();
         if (!arvalid_i) begin
            arvalid_i = 1'b1; araddr_i = 32'h100 + 32'(c); arprot_i = 3'($urandom);
         end
         if (!awvalid_i) begin
            awvalid_i = 1'b1; awaddr_i = 32'h200 + 32'(c); awprot_i = 3'($urandom);
         end
         if (!wvalid_i) begin
            wvalid_i = 1'b1; wdata_i = $urandom; wstrb_i = 4'($urandom);
         end
         #2;
         if (psel_o && !penable_o) begin
            order[n_grants] = pwrite_o;
            n_grants++;
         end
      end
      check_output("tie_count", 32'(n_grants), 32'd4);
      for (int i = 0; i < 4; i++) check_bit($sformatf("tie_grant%0d", i), order[i], (i % 2) == 1);
      tick();
      awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
      repeat (16) tick();

      // PSLVERR on a read, then a B response held off for ten cycles
      arvalid_i = 1'b1; araddr_i = 32'h80; arprot_i = 3'b000;
      pslverr_i = 1'b1; prdata_i = 32'hFFFFFFFF;
      tick(); tick(); tick(); tick(); #2;
      check_bit("err_rvalid", rvalid_o, 1'b1);
      check_output("err_rresp", 32'(rresp_o), 32'h2);
      check_output("err_rdata", rdata_o, 32'h0);
      tick();
      pslverr_i = 1'b0; bready_i = 1'b0; prdata_i = 32'h0BADF00D;
      awvalid_i = 1'b1; awaddr_i = 32'h20; awprot_i = 3'b000;
      wvalid_i = 1'b1; wdata_i = 32'h55AA55AA; wstrb_i = 4'b1001;
      tick();
      arvalid_i = 1'b1; araddr_i = 32'h84; arprot_i = 3'b100;
      tick(); tick(); tick();
      for (int k = 0; k < 10; k++) begin
         #2;
         check_bit($sformatf("bhold%0d_bvalid", k), bvalid_o, 1'b1);
         check_bit($sformatf("bhold%0d_psel", k), psel_o, 1'b0);
         tick();
      end
      bready_i = 1'b1;
      #2;
      check_bit("bhold_release_bvalid", bvalid_o, 1'b1);
      wait_rvalid("bhold_next_read", 10);
      check_output("bhold_next_rdata", rdata_o, 32'h0BADF00D);

      // Reset while in ACCESS, then a fresh read
      tick();
      pready_i = 1'b0;
      arvalid_i = 1'b1; araddr_i = 32'hC0; arprot_i = 3'b000;
      tick(); tick(); tick(); #2;
      check_bit("rst_acc_penable", penable_o, 1'b1);
      tick();
      rst_i = 1'b1;
      tick(); #2;
      check_bit("rst_acc_psel", psel_o, 1'b0);
      check_bit("rst_acc_penable_drop", penable_o, 1'b0);
      check_bit("rst_acc_rvalid", rvalid_o, 1'b0);
      check_bit("rst_acc_arready", arready_o, 1'b0);
      tick();
      rst_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #2;
         check_bit($sformatf("rst_after%0d_rvalid", k), rvalid_o, 1'b0);
         tick();
      end
      pready_i = 1'b1; prdata_i = 32'hCAFEF00D;
      arvalid_i = 1'b1; araddr_i = 32'h44; arprot_i = 3'b000;
      tick(); #2;
      wait_rvalid("fresh_read", 8);
      check_output("fresh_rdata", rdata_o, 32'hCAFEF00D);
      check_output("fresh_rresp", 32'(rresp_o), 32'h0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         apply_stimulus();
      end
      tick();
      rst_i = 1'b0;
      awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
      bready_i = 1'b1; rready_i = 1'b1; pready_i = 1'b1; pslverr_i = 1'b0;
      repeat (20) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
